vector_mem_responder: RTL

//  Memory-side responder for the vector unit's cache request/response interface.
//  It accepts vector_mem_req beats from the vector top's VMU port (mem_req_valid/cache_ready handshake) and queues them in order.
//  It services each beat against an internal line-wide scratchpad SRAM.
//  For every load it returns a vector_mem_resp with a fixed latency; stores produce no response.
//  It serves as the vector unit's scratchpad/L1 stand-in at SoC level and as the reference responder in vector benches.

---
 rtl/vector_mem_responder_pkg.sv | 36 +++
 rtl/vector_mem_responder_fifo.sv | 69 ++++++
 rtl/vector_mem_responder.sv | 95 +++++++++
 3 files changed

// File: rtl/vector_mem_responder_pkg.sv
// Shared vector memory types: request/response beats
// and the byte-merge helper used by the scratchpad.
package vector_mem_responder_pkg;

  localparam int REQ_DATA_WIDTH     = 256;
  localparam int VECTOR_TICKET_BITS = 4;
  localparam int VMEM_LINE_BYTES    = REQ_DATA_WIDTH / 8;
  localparam int VMEM_LB            = $clog2(VMEM_LINE_BYTES);

  typedef struct packed {
    logic [31:0]                   address;
    logic                          is_store;
    logic [VMEM_LINE_BYTES-1:0]    wr_mask;
    logic [REQ_DATA_WIDTH-1:0]     data;
    logic [VECTOR_TICKET_BITS-1:0] ticket;
  } vector_mem_req;

  typedef struct packed {
    logic [31:0]                   address;
    logic [REQ_DATA_WIDTH-1:0]     data;
    logic [VECTOR_TICKET_BITS-1:0] ticket;
  } vector_mem_resp;

  function automatic logic [REQ_DATA_WIDTH-1:0] vmem_merge(
    input logic [REQ_DATA_WIDTH-1:0]  old_d,
    input logic [REQ_DATA_WIDTH-1:0]  new_d,
    input logic [VMEM_LINE_BYTES-1:0] mask
  );
    logic [REQ_DATA_WIDTH-1:0] r;
    r = old_d;
    for (int b = 0; b < VMEM_LINE_BYTES; b++)
      if (mask[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/vector_mem_responder_fifo.sv
// Generic synchronous request FIFO with flush
// and a registered not-full flag.
module vmem_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_not_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             r_not_full;
  logic [CW-1:0]    w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt + CW'(i_push) - CW'(i_pop);
    if (i_flush) w_cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_not_full <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_not_full <= w_cnt_nxt < CW'(DEPTH);
      if (i_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (i_push) r_wptr <= r_wptr + 1'b1;
        if (i_pop)  r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

  assign o_data     = r_mem[r_rptr];
  assign o_empty    = (r_cnt == '0);
  assign o_not_full = r_not_full;

`ifndef SYNTHESIS
  a_push_ok: assert property (
    @(posedge clk) disable iff (!rst_n) i_push |-> r_not_full);
  a_pop_ok: assert property (
    @(posedge clk) disable iff (!rst_n) i_pop |-> !o_empty);
  a_cnt_ok: assert property (
    @(posedge clk) disable iff (!rst_n) r_cnt <= CW'(DEPTH));
`endif

endmodule

// File: rtl/vector_mem_responder.sv
// Scratchpad responder for the vector unit: in-order
// request queue, line-wide SRAM, fixed-latency load return.
module vector_mem_responder
  import vector_mem_responder_pkg::*;
#(
  parameter int MEM_LINES      = 256,
  parameter int REQ_FIFO_DEPTH = 4,
  parameter int RESP_LATENCY   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush_i,
  input  logic           mem_req_valid_i,
  input  vector_mem_req  mem_req_i,
  output logic           cache_ready_o,
  output logic           mem_resp_valid_o,
  output vector_mem_resp mem_resp_o
);

  localparam int IW = $clog2(MEM_LINES);
  localparam int RW = $bits(vector_mem_req);

  logic                      w_not_full;
  logic                      w_empty;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_ld;
  logic [RW-1:0]             w_head_bits;
  vector_mem_req             w_head;
  logic [IW-1:0]             w_idx;
  logic [REQ_DATA_WIDTH-1:0] w_rd;
  vector_mem_resp            w_resp;

  logic [REQ_DATA_WIDTH-1:0] r_sram [MEM_LINES];
  logic [RESP_LATENCY-1:0]   r_vld;
  vector_mem_resp            r_pipe [RESP_LATENCY];

  assign w_push = mem_req_valid_i & w_not_full & ~flush_i;
  assign w_pop  = ~w_empty & ~flush_i;

  vmem_req_fifo #(
    .WIDTH (RW),
    .DEPTH (REQ_FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_flush    (flush_i),
    .i_data     (mem_req_i),
    .o_data     (w_head_bits),
    .o_empty    (w_empty),
    .o_not_full (w_not_full)
  );

  assign w_head = w_head_bits;
  // Offset and upper address bits alias onto the same line
  assign w_idx  = w_head.address[VMEM_LB +: IW];
  assign w_rd   = r_sram[w_idx];
  assign w_ld   = w_pop & ~w_head.is_store;

  always_comb begin
    w_resp         = '0;
    w_resp.address = w_head.address;
    w_resp.data    = w_rd;
    w_resp.ticket  = w_head.ticket;
  end

  always_ff @(posedge clk) begin
    if (w_pop && w_head.is_store)
      r_sram[w_idx] <= vmem_merge(r_sram[w_idx],
                                  w_head.data,
                                  w_head.wr_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < RESP_LATENCY; i++)
        r_pipe[i] <= '0;
    end else begin
      r_vld[0] <= w_ld;
      if (w_ld) r_pipe[0] <= w_resp;
      for (int i = 1; i < RESP_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1] & ~flush_i;
        if (r_vld[i-1]) r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign cache_ready_o    = w_not_full;
  assign mem_resp_valid_o = r_vld[RESP_LATENCY-1];
  assign mem_resp_o       = r_pipe[RESP_LATENCY-1];

endmodule
